// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO on the data bus.
// Define UART_TX_IRQ_EN to add the CTRL register and the irq output.
module mmio_uart_tx #(
   parameter logic [15:0] BASE_ADDR   = 16'h00F0,
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] mem_access_addr,
   input  logic [15:0] mem_write_data,
   input  logic        mem_write_en,
   input  logic        mem_read,
   output logic [15:0] mem_read_data,
   output logic        tx
`ifdef UART_TX_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t         state;
   logic           sel;
   logic [1:0]     off;
   logic           wr_en;
   logic [7:0]     fifo [FIFO_DEPTH];
   logic [AW-1:0]  wptr;
   logic [AW-1:0]  rptr;
   logic [CW-1:0]  count;
   logic           full;
   logic           empty;
   logic           push_req;
   logic           push;
   logic           pop;
   logic           ovf;
   logic [15:0]    baud;
   logic [7:0]     shift;
   logic [2:0]     bit_idx;
   logic [15:0]    div;
   logic [15:0]    cnt;
   logic           bit_end;
   logic           busy;
   logic [15:0]    status;
`ifdef UART_TX_IRQ_EN
   logic           ie;
`endif

   assign sel      = mem_access_addr[15:2] == BASE_ADDR[15:2];
   assign off      = mem_access_addr[1:0];
   assign wr_en    = sel & mem_write_en;
   assign full     = count == CW'(FIFO_DEPTH);
   assign empty    = count == '0;
   assign busy     = state != IDLE;
   assign bit_end  = cnt == div - 16'd1;
   assign pop      = !empty && (state == IDLE || (state == STOP && bit_end));
   assign push_req = wr_en && off == 2'd0;
   // A pop in the same cycle frees a slot, so a full FIFO may still accept.
   assign push     = push_req && (!full || pop);
   assign status   = {8'd0, 4'(count), ovf, empty, full, busy};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
         baud  <= DEFAULT_DIV;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
`ifdef UART_TX_IRQ_EN
         ie    <= 1'b0;
         irq   <= 1'b0;
`endif
      end else begin
         if (push) begin
            fifo[wptr] <= mem_write_data[7:0];
            wptr       <= wptr + AW'(1);
         end
         if (pop) rptr <= rptr + AW'(1);
         if (push && !pop) count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
         if (push_req && !push) ovf <= 1'b1;
         else if (wr_en && off == 2'd1 && mem_write_data[3]) ovf <= 1'b0;
         if (wr_en && off == 2'd2)
            baud <= (mem_write_data == 16'd0) ? 16'd1 : mem_write_data;
`ifdef UART_TX_IRQ_EN
         if (wr_en && off == 2'd3) ie <= mem_write_data[0];
         irq <= ie & empty & (state == IDLE);
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         tx      <= 1'b1;
         shift   <= '0;
         bit_idx <= '0;
         div     <= DEFAULT_DIV;
         cnt     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pop) begin
                  shift <= fifo[rptr];
                  div   <= baud;
                  cnt   <= '0;
                  tx    <= 1'b0;
                  state <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  cnt     <= '0;
                  tx      <= shift[0];
                  shift   <= shift >> 1;
                  bit_idx <= '0;
                  state   <= DATA;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     tx      <= shift[0];
                     shift   <= shift >> 1;
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  cnt <= '0;
                  // Back-to-back frames: reload without passing through IDLE.
                  if (pop) begin
                     shift <= fifo[rptr];
                     div   <= baud;
                     tx    <= 1'b0;
                     state <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      mem_read_data = 16'd0;
      if (sel && mem_read) begin
         case (off)
            2'd1:    mem_read_data = status;
            2'd2:    mem_read_data = baud;
`ifdef UART_TX_IRQ_EN
            2'd3:    mem_read_data = {15'd0, ie};
`endif
            default: mem_read_data = 16'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx.
// Covers reset, framing, overflow, baud change, decode and mid-frame reset.
module tb_mmio_uart_tx;

   localparam logic [15:0] A_TX   = 16'h00F0;
   localparam logic [15:0] A_STAT = 16'h00F1;
   localparam logic [15:0] A_BAUD = 16'h00F2;
   localparam logic [15:0] A_CTRL = 16'h00F3;

   logic        clk;
   logic        rst_n;
   logic [15:0] mem_access_addr;
   logic [15:0] mem_write_data;
   logic        mem_write_en;
   logic        mem_read;
   logic [15:0] mem_read_data;
   logic        tx;
`ifdef UART_TX_IRQ_EN
   logic        irq;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   mmio_uart_tx dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .mem_access_addr (mem_access_addr),
      .mem_write_data  (mem_write_data),
      .mem_write_en    (mem_write_en),
      .mem_read        (mem_read),
      .mem_read_data   (mem_read_data),
      .tx              (tx)
`ifdef UART_TX_IRQ_EN
      ,
      .irq             (irq)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [15:0] got,
                        input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      mem_access_addr = a;
      mem_write_data  = d;
      mem_write_en    = 1'b1;
      @(posedge clk);
      #1;
      mem_write_en    = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, output logic [15:0] v);
      mem_access_addr = a;
      mem_read        = 1'b1;
      #1;
      v               = mem_read_data;
      mem_read        = 1'b0;
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Sample each bit at its middle; base is the edge where tx went low.
   task automatic sample_frame(input int base, input int d,
                               output logic [9:0] f);
      for (int i = 0; i < 10; i++) begin
         wait_cyc(base + d * i + d / 2);
         f[i] = tx;
      end
   endtask

   logic [15:0] v;
   logic [9:0]  fr;
   int          n;
   int          low;

   initial begin
      rst_n           = 1'b0;
      mem_access_addr = '0;
      mem_write_data  = '0;
      mem_write_en    = 1'b0;
      mem_read        = 1'b0;
      #23;
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // Reset state
      check("rst_tx", {15'd0, tx}, 16'd1);
      rd(A_STAT, v); check("rst_status", v, 16'h0004);
      rd(A_BAUD, v); check("rst_baud", v, 16'd16);
      rd(A_CTRL, v); check("rst_off3", v, 16'd0);
      rd(A_TX, v);   check("rd_txdata", v, 16'd0);
      mem_access_addr = A_STAT;
      #1;
      check("rd_no_enable", mem_read_data, 16'd0);
`ifdef UART_TX_IRQ_EN
      check("rst_irq", {15'd0, irq}, 16'd0);
`endif

      // Single byte 0x55 at D=16
      wr(A_TX, 16'h0055);
      n = cyc;
      check("single_k0_tx", {15'd0, tx}, 16'd1);
      wait_cyc(n + 1);
      check("single_k1_tx", {15'd0, tx}, 16'd0);
      rd(A_STAT, v); check("single_busy_k1", v, 16'h0005);
      sample_frame(n + 1, 16, fr);
      check("single_frame", {6'd0, fr}, {6'd0, 1'b1, 8'h55, 1'b0});
      wait_cyc(n + 160);
      rd(A_STAT, v); check("single_busy_k160", v & 16'h0001, 16'h0001);
      wait_cyc(n + 161);
      rd(A_STAT, v); check("single_idle_k161", v, 16'h0004);

      // Overflow: A0..A5 on consecutive cycles
      wr(A_TX, 16'h00A0);
      n = cyc;
      for (int i = 1; i < 6; i++) wr(A_TX, 16'h00A0 + 16'(i));
      rd(A_STAT, v); check("ovf_status", v, 16'h004B);
      wr(A_STAT, 16'h0008);
      rd(A_STAT, v); check("ovf_cleared", v, 16'h0043);
      for (int f = 0; f < 5; f++) begin
         sample_frame(n + 1 + 160 * f, 16, fr);
         check($sformatf("ovf_frame%0d", f), {6'd0, fr},
               {6'd0, 1'b1, 8'hA0 + 8'(f), 1'b0});
      end
      wait_cyc(n + 800);
      rd(A_STAT, v); check("ovf_busy_end", v & 16'h0001, 16'h0001);
      wait_cyc(n + 801);
      rd(A_STAT, v); check("ovf_idle_end", v, 16'h0004);

      // Baud change mid-frame
      wr(A_TX, 16'h003C);
      n = cyc;
      wr(A_TX, 16'h00A5);
      wr(A_BAUD, 16'h0000);
      rd(A_BAUD, v); check("baud_zero_as_one", v, 16'd1);
      sample_frame(n + 1, 16, fr);
      check("baud_frame_old", {6'd0, fr}, {6'd0, 1'b1, 8'h3C, 1'b0});
      wait_cyc(n + 160);
      rd(A_STAT, v); check("baud_old_len", v & 16'h0001, 16'h0001);
      sample_frame(n + 161, 1, fr);
      check("baud_frame_new", {6'd0, fr}, {6'd0, 1'b1, 8'hA5, 1'b0});
      wait_cyc(n + 170);
      rd(A_STAT, v); check("baud_new_busy", v & 16'h0001, 16'h0001);
      wait_cyc(n + 171);
      rd(A_STAT, v); check("baud_new_idle", v, 16'h0004);
      wr(A_BAUD, 16'd16);

      // Address isolation
      wr(16'h00F4, 16'h0077);
      wr(16'h01F0, 16'h0066);
      rd(16'h00F5, v); check("iso_rd_f5", v, 16'd0);
      rd(16'h01F1, v); check("iso_rd_1f1", v, 16'd0);
      n = cyc;
      wait_cyc(n + 4);
      rd(A_STAT, v); check("iso_status", v, 16'h0004);
      check("iso_tx", {15'd0, tx}, 16'd1);

`ifdef UART_TX_IRQ_EN
      wr(A_CTRL, 16'h0001);
      n = cyc;
      rd(A_CTRL, v); check("irq_ctrl_rd", v, 16'd1);
      wait_cyc(n + 1);
      check("irq_set", {15'd0, irq}, 16'd1);
      wr(A_TX, 16'h0081);
      n = cyc;
      wait_cyc(n + 1);
      check("irq_push_clr", {15'd0, irq}, 16'd0);
      wait_cyc(n + 161);
      check("irq_frame_end", {15'd0, irq}, 16'd0);
      wait_cyc(n + 162);
      check("irq_after_frame", {15'd0, irq}, 16'd1);
`endif

      // Reset asserted during DATA
      wr(A_TX, 16'h000F);
      n = cyc;
      wr(A_TX, 16'h0033);
      wait_cyc(n + 40);
      check("mid_tx_data", {15'd0, tx}, 16'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_tx", {15'd0, tx}, 16'd1);
      rd(A_STAT, v); check("mid_rst_status", v, 16'h0004);
      @(negedge clk);
      rst_n = 1'b1;
      low = 0;
      repeat (200) begin
         @(posedge clk);
         #1;
         if (!tx) low++;
      end
      check("mid_no_frame", 16'(low), 16'd0);
      rd(A_STAT, v); check("mid_post_status", v, 16'h0004);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
